vga_sync_decoder: RTL



---
 rtl/vga_sync_decoder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers pixel coordinates from hs/vs pulses,
// measures line/frame timing and reports lock.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 1056,
  parameter int V_TOTAL     = 628,
  parameter int HA_OFS      = 216,
  parameter int HA_WIDTH    = 800,
  parameter int VA_OFS      = 27,
  parameter int VA_HEIGHT   = 600,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  input  logic        i_hs,
  input  logic        i_vs,
  output logic [10:0] o_x,
  output logic [9:0]  o_y,
  output logic        o_active,
  output logic        o_locked,
  output logic        o_frame_start,
  output logic        o_err,
  output logic [10:0] o_line_len
);

  localparam int GW = (LOCK_FRAMES > 1)
                    ? $clog2(LOCK_FRAMES + 1) : 1;

  localparam logic [11:0] HTOT  = 12'(H_TOTAL);
  localparam logic [10:0] VTOT  = 11'(V_TOTAL);
  localparam logic [11:0] HA_LO = 12'(HA_OFS);
  localparam logic [11:0] HA_HI = 12'(HA_OFS + HA_WIDTH);
  localparam logic [10:0] HA_X  = 11'(HA_OFS);
  localparam logic [10:0] VA_LO = 11'(VA_OFS);
  localparam logic [10:0] VA_HI = 11'(VA_OFS + VA_HEIGHT);
  localparam logic [9:0]  VA_Y  = 10'(VA_OFS);
  localparam logic [GW-1:0] GMAX = GW'(LOCK_FRAMES);

  localparam logic [10:0] H_SAT = 11'h7FF;
  localparam logic [9:0]  V_SAT = 10'h3FF;

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } state_e;

  state_e state_q, state_d;

  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          vs_pend_q, vs_pend_d;
  logic          first_q, first_d;
  logic          seen_q, seen_d;
  logic          lbad_q, lbad_d;
  logic [10:0]   h_cnt_q, h_cnt_d;
  logic [9:0]    v_cnt_q, v_cnt_d;
  logic [10:0]   len_q, len_d;
  logic [GW-1:0] good_q, good_d;
  logic          fs_q, fs_d;
  logic          err_q, err_d;

  logic        hs_rise;
  logic        vs_rise;
  logic        vs_now;
  logic [11:0] h_inc;
  logic [10:0] v_inc;
  logic        line_err;
  logic        frm_chk;
  logic        frm_bad;
  logic        frm_good;
  logic        any_err;
  logic        h_in;
  logic        v_in;

  assign hs_rise  = i_pix_stb & i_hs & ~hs_q;
  assign vs_rise  = i_pix_stb & i_vs & ~vs_q;
  assign vs_now   = vs_pend_q | vs_rise;
  assign h_inc    = {1'b0, h_cnt_q} + 12'd1;
  assign v_inc    = {1'b0, v_cnt_q} + 11'd1;
  assign line_err = hs_rise & ~first_q & (h_inc != HTOT);
  assign frm_chk  = hs_rise & vs_now & seen_q;
  assign frm_bad  = frm_chk
                  & ((v_inc != VTOT) | lbad_q | line_err);
  assign frm_good = frm_chk & ~frm_bad;
  assign any_err  = line_err | frm_bad;

  // next-state for counters, measurements and pulses
  always_comb begin
    hs_d      = hs_q;
    vs_d      = vs_q;
    vs_pend_d = vs_pend_q;
    first_d   = first_q;
    seen_d    = seen_q;
    lbad_d    = lbad_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    len_d     = len_q;
    good_d    = good_q;
    fs_d      = 1'b0;
    err_d     = 1'b0;
    if (i_pix_stb) begin
      hs_d  = i_hs;
      vs_d  = i_vs;
      err_d = any_err;
      if (hs_rise) begin
        h_cnt_d   = '0;
        len_d     = (h_cnt_q == H_SAT) ? H_SAT : h_inc[10:0];
        first_d   = 1'b0;
        vs_pend_d = 1'b0;
        if (vs_now) begin
          v_cnt_d = '0;
          fs_d    = 1'b1;
          seen_d  = 1'b1;
          lbad_d  = 1'b0;
        end else begin
          lbad_d = lbad_q | line_err;
          if (v_cnt_q != V_SAT) begin
            v_cnt_d = v_inc[9:0];
          end
        end
      end else begin
        vs_pend_d = vs_now;
        if (h_cnt_q != H_SAT) begin
          h_cnt_d = h_inc[10:0];
        end
      end
      if (any_err) begin
        good_d = '0;
      end else if (frm_good && good_q != GMAX) begin
        good_d = good_q + 1'b1;
      end
    end
  end

  // lock state: enter on final good frame, leave on any error
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UNLOCKED: if (good_d == GMAX) state_d = LOCKED;
      LOCKED:   if (any_err)        state_d = UNLOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  // state registers, synchronous reset has priority
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= UNLOCKED;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      vs_pend_q <= 1'b0;
      first_q   <= 1'b1;
      seen_q    <= 1'b0;
      lbad_q    <= 1'b0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      len_q     <= '0;
      good_q    <= '0;
      fs_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      vs_pend_q <= vs_pend_d;
      first_q   <= first_d;
      seen_q    <= seen_d;
      lbad_q    <= lbad_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      len_q     <= len_d;
      good_q    <= good_d;
      fs_q      <= fs_d;
      err_q     <= err_d;
    end
  end

  // coordinates decoded from the live counters
  always_comb begin
    h_in = ({1'b0, h_cnt_q} >= HA_LO)
         & ({1'b0, h_cnt_q} <  HA_HI);
    v_in = ({1'b0, v_cnt_q} >= VA_LO)
         & ({1'b0, v_cnt_q} <  VA_HI);
    o_x      = h_in ? (h_cnt_q - HA_X) : '0;
    o_y      = v_in ? (v_cnt_q - VA_Y) : '0;
    o_active = o_locked & h_in & v_in;
  end

  assign o_locked      = (state_q == LOCKED);
  assign o_frame_start = fs_q;
  assign o_err         = err_q;
  assign o_line_len    = len_q;

endmodule
